// File: rtl/arb_req_queue.sv
`default_nettype none
// ============================================================================
// arb_req_queue : per-port request FIFOs and client-side FSM for a
//                 round-robin arbiter (req/en/gnt), single valid/ready output.
// Rev 1.0
// ============================================================================
module arb_req_queue #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N-1:0]         i_push,
  input  logic [N*W-1:0]       i_push_data,
  output logic [N-1:0]         o_full,
  output logic [N-1:0]         o_req,
  output logic                 o_arb_en,
  input  logic [N-1:0]         i_gnt,
  output logic                 o_valid,
  output logic [W-1:0]         o_data,
  output logic [$clog2(N)-1:0] o_src,
  input  logic                 i_ready,
  output logic                 o_err
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;
  localparam int c_sw = $clog2(N);
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            arb_en_q, arb_en_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    data_q, data_d;
  logic [c_sw-1:0] src_q, src_d;
  logic            err_q, err_d;

  logic [N-1:0]        w_pop;
  logic [N-1:0]        w_push_ok;
  logic [N-1:0][W-1:0] w_head;
  logic                w_gnt_ok;
  logic [c_sw-1:0]     w_gnt_idx;
  logic [W-1:0]        w_head_sel;

  // A grant is only honoured when it is one-hot and names a non-empty port.
  assign w_gnt_ok = $onehot(i_gnt) && ((i_gnt & o_req) != '0);

  always_comb begin
    w_gnt_idx  = '0;
    w_head_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (i_gnt[k]) begin
        w_gnt_idx  = c_sw'(k);
        w_head_sel = w_head[k];
      end
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_port
      logic [W-1:0]    mem_q [DEPTH];
      logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
      logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
      logic [c_cw-1:0] cnt_q, cnt_d;

      assign o_full[k]    = (cnt_q == c_full);
      assign o_req[k]     = (cnt_q != '0);
      assign w_head[k]    = mem_q[rd_ptr_q];
      assign w_pop[k]     = (state_q == WAIT) && w_gnt_ok && i_gnt[k];
      // A full FIFO still takes a push in the cycle it is being popped.
      assign w_push_ok[k] = i_push[k] && (!o_full[k] || w_pop[k]);

      always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (w_pop[k]) begin
          rd_ptr_d = rd_ptr_q + c_pw'(1);
        end
        if (w_push_ok[k]) begin
          wr_ptr_d = wr_ptr_q + c_pw'(1);
        end
        case ({w_push_ok[k], w_pop[k]})
          2'b10:   cnt_d = cnt_q + c_cw'(1);
          2'b01:   cnt_d = cnt_q - c_cw'(1);
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
          wr_ptr_q <= wr_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      always_ff @(posedge i_clk) begin
        if (w_push_ok[k]) begin
          mem_q[wr_ptr_q] <= i_push_data[k*W +: W];
        end
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    arb_en_d = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    src_d    = src_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (|o_req) begin
          state_d  = REQ;
          arb_en_d = 1'b1;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (w_gnt_ok) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = w_head_sel;
          src_d   = w_gnt_idx;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      SEND: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (|o_req) begin
            state_d  = REQ;
            arb_en_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      arb_en_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      arb_en_q <= arb_en_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      src_q    <= src_d;
      err_q    <= err_d;
    end
  end

  assign o_arb_en = arb_en_q;
  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_src    = src_q;
  assign o_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_req_queue.sv
`default_nettype none
// ============================================================================
// tb_arb_req_queue : directed and random scenarios against a queue model,
//                    with a bench-side round-robin arbiter answering o_arb_en.
// Rev 1.0
// ============================================================================
module tb_arb_req_queue;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int SW    = 2;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   i_push;
  logic [N*W-1:0] i_push_data;
  logic [N-1:0]   o_full;
  logic [N-1:0]   o_req;
  logic           o_arb_en;
  logic [N-1:0]   i_gnt;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic [SW-1:0]  o_src;
  logic           i_ready;
  logic           o_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  data;
  } txn_t;

  logic [W-1:0] mq [N][$];
  txn_t         exp_q[$];
  txn_t         delivered[$];
  logic         exp_err;
  int           acc_cnt;

  int           arb_ptr;
  logic [N-1:0] saved_req;
  bit           pending;
  logic [N-1:0] gnt_ovr[$];

  always #5 clk = ~clk;

  arb_req_queue #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_push      (i_push),
    .i_push_data (i_push_data),
    .o_full      (o_full),
    .o_req       (o_req),
    .o_arb_en    (o_arb_en),
    .i_gnt       (i_gnt),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_src       (o_src),
    .i_ready     (i_ready),
    .o_err       (o_err)
  );

  // Registered round-robin arbiter: samples o_req in the o_arb_en cycle,
  // presents the grant during the following cycle only.
  initial begin : p_arbiter
    int idx;
    i_gnt   = '0;
    pending = 1'b0;
    arb_ptr = 0;
    forever begin
      @(posedge clk);
      #1;
      i_gnt = '0;
      if (!rstn) begin
        pending = 1'b0;
        continue;
      end
      if (pending) begin
        pending = 1'b0;
        if (gnt_ovr.size() != 0) begin
          i_gnt = gnt_ovr.pop_front();
        end else begin
          for (int i = 0; i < N; i++) begin
            idx = (arb_ptr + i) % N;
            if (saved_req[idx]) begin
              i_gnt[idx] = 1'b1;
              arb_ptr    = (idx + 1) % N;
              break;
            end
          end
        end
      end
      if (o_arb_en) begin
        saved_req = o_req;
        pending   = 1'b1;
      end
    end
  end

  // Reference model: one queue per port, expected-transaction queue, sticky error.
  initial begin : p_monitor
    logic         en_last;
    logic         good;
    logic [N-1:0] exp_req;
    logic [N-1:0] exp_full;
    txn_t         t;
    txn_t         dropped;
    en_last = 1'b0;
    exp_err = 1'b0;
    acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        en_last = 1'b0;
        continue;
      end
      for (int k = 0; k < N; k++) begin
        exp_req[k]  = (mq[k].size() != 0);
        exp_full[k] = (mq[k].size() == DEPTH);
      end
      n_checks++;
      if (o_req !== exp_req) $display("FAIL mon_req: o_req=%b expected %b at %0t", o_req, exp_req, $time);
      else n_pass++;
      n_checks++;
      if (o_full !== exp_full) $display("FAIL mon_full: o_full=%b expected %b at %0t", o_full, exp_full, $time);
      else n_pass++;
      n_checks++;
      if (o_err !== exp_err) $display("FAIL mon_err: o_err=%b expected %b at %0t", o_err, exp_err, $time);
      else n_pass++;
      n_checks++;
      if (o_valid !== (exp_q.size() != 0))
        $display("FAIL mon_valid: o_valid=%b expected %b at %0t", o_valid, (exp_q.size() != 0), $time);
      else n_pass++;
      n_checks++;
      if (o_arb_en === 1'b1 && o_valid === 1'b1)
        $display("FAIL mon_en_in_send: o_arb_en=%b o_valid=%b expected not both at %0t", o_arb_en, o_valid, $time);
      else n_pass++;
      if (o_valid === 1'b1 && exp_q.size() != 0) begin
        n_checks++;
        if ({o_src, o_data} !== {exp_q[0].src, exp_q[0].data})
          $display("FAIL mon_txn: src=%0d data=%h expected src=%0d data=%h at %0t",
                   o_src, o_data, exp_q[0].src, exp_q[0].data, $time);
        else n_pass++;
      end
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        t.src  = o_src;
        t.data = o_data;
        delivered.push_back(t);
        if (exp_q.size() != 0) dropped = exp_q.pop_front();
      end
      if (en_last) begin
        good = 1'b0;
        if ($onehot(i_gnt)) begin
          for (int k = 0; k < N; k++) begin
            if (i_gnt[k] && mq[k].size() != 0) begin
              t.src  = SW'(k);
              t.data = mq[k].pop_front();
              exp_q.push_back(t);
              good = 1'b1;
            end
          end
        end
        if (!good) exp_err = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        if (i_push[k] && mq[k].size() < DEPTH) begin
          mq[k].push_back(i_push_data[k*W +: W]);
          acc_cnt++;
        end
      end
      en_last = o_arb_en;
    end
  end

  task automatic drain(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!o_valid && o_req == '0 && !o_arb_en && exp_q.size() == 0) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    i_push      = '0;
    i_push_data = '0;
    i_ready     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_req, o_full, o_arb_en, o_valid, o_data, o_src, o_err} !== '0)
      $display("FAIL reset_outputs: req=%b full=%b en=%b valid=%b data=%h src=%0d err=%b expected all zero",
               o_req, o_full, o_arb_en, o_valid, o_data, o_src, o_err);
    else n_pass++;
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_single_push();
    i_ready                = 1'b1;
    i_push_data            = '0;
    i_push_data[2*W +: W]  = 8'hA5;
    i_push                 = 4'b0100;
    @(posedge clk);
    #2;
    i_push = '0;
    @(negedge clk);
    n_checks++;
    if ({o_req, o_arb_en} !== {4'b0100, 1'b0})
      $display("FAIL single_c1: req=%b en=%b expected req=0100 en=0", o_req, o_arb_en);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_arb_en !== 1'b1) $display("FAIL single_c2_en: o_arb_en=%b expected 1", o_arb_en);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({o_arb_en, o_valid} !== 2'b00) $display("FAIL single_c3: en=%b valid=%b expected 0 0", o_arb_en, o_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_data, o_src} !== {1'b1, 8'hA5, 2'd2})
      $display("FAIL single_c4: valid=%b data=%h src=%0d expected 1 a5 2", o_valid, o_data, o_src);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_req} !== 5'b0)
      $display("FAIL single_after: valid=%b req=%b expected 0 0000", o_valid, o_req);
    else n_pass++;
    @(posedge clk);
    #2;
  endtask

  task automatic test_all_ports();
    bit           ok;
    int           n;
    int           cyc;
    logic         prev;
    int           rise [4];
    logic [SW-1:0] src [4];
    logic [W-1:0]  dat [4];
    logic [W-1:0]  want;
    drain(60, ok);
    n_checks++;
    if (!ok) $display("FAIL all_drain_timeout: ok=%b expected 1", ok);
    else n_pass++;
    arb_ptr     = 0;
    i_ready     = 1'b1;
    i_push_data = {8'h13, 8'h12, 8'h11, 8'h10};
    i_push      = '1;
    @(posedge clk);
    #2;
    i_push = '0;
    n    = 0;
    prev = 1'b0;
    for (cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk);
      if (o_valid && !prev) begin
        rise[n] = cyc;
        src[n]  = o_src;
        dat[n]  = o_data;
        n++;
      end
      prev = o_valid;
    end
    n_checks++;
    if (n != 4) $display("FAIL all_count: transactions=%0d expected 4", n);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      want = 8'h10 + 8'(i);
      n_checks++;
      if ({src[i], dat[i]} !== {SW'(i), want})
        $display("FAIL all_order: slot %0d src=%0d data=%h expected src=%0d data=%h", i, src[i], dat[i], i, want);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (rise[i] - rise[i-1] != 3)
          $display("FAIL all_spacing: slot %0d gap=%0d expected 3", i, rise[i] - rise[i-1]);
        else n_pass++;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_fifo_full();
    bit ok;
    drain(60, ok);
    i_ready               = 1'b0;
    i_push_data           = '0;
    i_push_data[0 +: W]   = 8'h77;
    i_push                = 4'b0001;
    @(posedge clk);
    #2;
    i_push = '0;
    wait_valid(20, ok);
    n_checks++;
    if (!ok) $display("FAIL full_wait_valid: ok=%b expected 1", ok);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        n_checks++;
        if (o_full[1] !== 1'b1) $display("FAIL full_after4: o_full[1]=%b expected 1", o_full[1]);
        else n_pass++;
      end
      i_push_data         = '0;
      i_push_data[W +: W] = 8'(i);
      i_push              = 4'b0010;
      @(posedge clk);
      #2;
    end
    i_push = '0;
    @(negedge clk);
    n_checks++;
    if (o_full[1] !== 1'b1) $display("FAIL full_after5: o_full[1]=%b expected 1", o_full[1]);
    else n_pass++;
    @(posedge clk);
    #2;
    delivered.delete();
    i_ready = 1'b1;
    drain(80, ok);
    n_checks++;
    if (!ok || delivered.size() != 5)
      $display("FAIL full_drain: ok=%b delivered=%0d expected ok=1 delivered=5", ok, delivered.size());
    else n_pass++;
    for (int i = 1; i < delivered.size() && i < 5; i++) begin
      n_checks++;
      if ({delivered[i].src, delivered[i].data} !== {2'd1, 8'(i)})
        $display("FAIL full_order: slot %0d src=%0d data=%h expected src=1 data=%h",
                 i, delivered[i].src, delivered[i].data, 8'(i));
      else n_pass++;
    end
    n_checks++;
    if (o_req[1] !== 1'b0) $display("FAIL full_req_clear: o_req[1]=%b expected 0", o_req[1]);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit           ok;
    logic [W-1:0] d3, d0, d1;
    drain(60, ok);
    d3 = W'($urandom);
    d0 = W'($urandom);
    d1 = W'($urandom);
    delivered.delete();
    i_ready             = 1'b0;
    i_push_data         = '0;
    i_push_data[3*W +: W] = d3;
    i_push              = 4'b1000;
    @(posedge clk);
    #2;
    i_push = '0;
    wait_valid(20, ok);
    n_checks++;
    if (!ok) $display("FAIL stall_wait_valid: ok=%b expected 1", ok);
    else n_pass++;
    for (int j = 0; j < 10; j++) begin
      if (j == 1) begin
        i_push_data         = '0;
        i_push_data[0 +: W] = d0;
        i_push_data[W +: W] = d1;
        i_push              = 4'b0011;
      end else begin
        i_push = '0;
      end
      @(negedge clk);
      n_checks++;
      if ({o_valid, o_data, o_src, o_arb_en} !== {1'b1, d3, 2'd3, 1'b0})
        $display("FAIL stall_hold: cycle %0d valid=%b data=%h src=%0d en=%b expected 1 %h 3 0",
                 j, o_valid, o_data, o_src, o_arb_en, d3);
      else n_pass++;
      if (j == 3) begin
        n_checks++;
        if (o_req[1:0] !== 2'b11) $display("FAIL stall_req: o_req=%b expected xx11", o_req);
        else n_pass++;
      end
      @(posedge clk);
      #2;
    end
    i_ready = 1'b1;
    drain(60, ok);
    n_checks++;
    if (!ok || delivered.size() != 3)
      $display("FAIL stall_drain: ok=%b delivered=%0d expected ok=1 delivered=3", ok, delivered.size());
    else n_pass++;
    if (delivered.size() == 3) begin
      n_checks++;
      if ({delivered[0], delivered[1], delivered[2]} !== {2'd3, d3, 2'd0, d0, 2'd1, d1})
        $display("FAIL stall_order: got %0d:%h %0d:%h %0d:%h expected 3:%h 0:%h 1:%h",
                 delivered[0].src, delivered[0].data, delivered[1].src, delivered[1].data,
                 delivered[2].src, delivered[2].data, d3, d0, d1);
      else n_pass++;
    end
  endtask

  task automatic test_bad_grant();
    bit           ok;
    logic [W-1:0] d;
    drain(60, ok);
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL err_initial: o_err=%b expected 0", o_err);
    else n_pass++;
    d = W'($urandom);
    delivered.delete();
    gnt_ovr.push_back(4'b0000);
    gnt_ovr.push_back(4'b0011);
    i_ready               = 1'b1;
    i_push_data           = '0;
    i_push_data[2*W +: W] = d;
    i_push                = 4'b0100;
    @(posedge clk);
    #2;
    i_push = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({o_err, o_valid, o_req[2]} !== 3'b101)
      $display("FAIL err_zero_gnt: err=%b valid=%b req2=%b expected 1 0 1", o_err, o_valid, o_req[2]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_arb_en !== 1'b1) $display("FAIL err_rereq: o_arb_en=%b expected 1", o_arb_en);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_err, o_valid, o_req[2]} !== 3'b101)
      $display("FAIL err_multi_gnt: err=%b valid=%b req2=%b expected 1 0 1", o_err, o_valid, o_req[2]);
    else n_pass++;
    @(posedge clk);
    #2;
    drain(60, ok);
    n_checks++;
    if (!ok || delivered.size() != 1 || {delivered[0].src, delivered[0].data} !== {2'd2, d})
      $display("FAIL err_delivery: ok=%b delivered=%0d first=%0d:%h expected 1 1 2:%h",
               ok, delivered.size(), (delivered.size() != 0) ? delivered[0].src : 2'd0,
               (delivered.size() != 0) ? delivered[0].data : 8'd0, d);
    else n_pass++;
    n_checks++;
    if (o_err !== 1'b1) $display("FAIL err_sticky: o_err=%b expected 1", o_err);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int acc_before;
    drain(60, ok);
    delivered.delete();
    acc_before = acc_cnt;
    for (int i = 0; i < 400; i++) begin
      i_push      = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      i_push_data = (N*W)'($urandom);
      i_ready     = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
    end
    i_push  = '0;
    i_ready = 1'b1;
    drain(200, ok);
    n_checks++;
    if (!ok || delivered.size() != acc_cnt - acc_before)
      $display("FAIL random_drain: ok=%b delivered=%0d expected ok=1 delivered=%0d",
               ok, delivered.size(), acc_cnt - acc_before);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int vcount;
    drain(60, ok);
    i_ready             = 1'b0;
    i_push_data         = '0;
    i_push_data[0 +: W] = 8'h3C;
    i_push              = 4'b0001;
    @(posedge clk);
    #2;
    i_push = '0;
    wait_valid(20, ok);
    i_push_data         = '0;
    i_push_data[W +: W] = 8'h5A;
    i_push              = 4'b0010;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    i_push = '0;
    @(negedge clk);
    n_checks++;
    if ({ok, o_valid, o_req} !== {1'b1, 1'b1, 4'b0010})
      $display("FAIL rstmid_setup: ok=%b valid=%b req=%b expected 1 1 0010", ok, o_valid, o_req);
    else n_pass++;
    #1;
    rstn = 1'b0;
    for (int k = 0; k < N; k++) mq[k].delete();
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    n_checks++;
    if ({o_req, o_full, o_arb_en, o_valid, o_data, o_src, o_err} !== '0)
      $display("FAIL rstmid_async: req=%b full=%b en=%b valid=%b data=%h src=%0d err=%b expected all zero",
               o_req, o_full, o_arb_en, o_valid, o_data, o_src, o_err);
    else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    rstn    = 1'b1;
    i_ready = 1'b1;
    delivered.delete();
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (o_valid || o_req != '0) vcount++;
    end
    n_checks++;
    if (vcount != 0 || delivered.size() != 0)
      $display("FAIL rstmid_stale: active cycles=%0d delivered=%0d expected 0 0", vcount, delivered.size());
    else n_pass++;
  endtask

  initial begin : p_main
    test_reset();
    test_single_push();
    test_all_ports();
    test_fifo_full();
    test_stall();
    test_bad_grant();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
